// File: rtl/display_scan_if.sv
// Digit-write / commit handshake bundle for display_scan_controller.
//
// Signals:
//   wr_valid    - digit write request                   (master -> slave)
//   wr_ready    - write accepted when wr_valid&&wr_ready (slave -> master)
//   wr_addr     - digit index, 0 = rightmost (an[0])     (master -> slave)
//   wr_data     - BCD/code value, 4'hF = blank code      (master -> slave)
//   wr_commit   - copy shadow to live at next frame      (master -> slave)
//   commit_done - one-cycle pulse when the copy happens  (slave -> master)
interface display_scan_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_commit;
  logic       commit_done;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_commit,
    input  wr_ready, commit_done
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_commit,
    output wr_ready, commit_done
  );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Holds a shadow digit bank (written through the handshake bus) and a live
// bank (what is displayed). The shadow bank is copied to the live bank only at
// a frame boundary so a frame never shows a mix of old and new digits.
// Each digit slot is DIVISOR cycles: BLANK_CYCLES with all anodes off, then
// the rest with the selected anode on.
//
// Ports:
//   clk         - system clock
//   rst         - synchronous reset, active-high
//   bus         - display_scan_if.slave (wr_valid/wr_ready/wr_addr/wr_data,
//                 wr_commit, commit_done)
//   digit_en    - per-digit enable, 0 keeps that anode off in its slot
//   brightness  - 4-bit duty setting (only with BRIGHTNESS_PWM_EN)
//   frame_start - one-cycle pulse on the first cycle of digit 0's slot
//   bcd_out     - code of the currently lit digit, 4'hF while blanked
//   an          - active-low anodes, at most one bit low
//
// Optional feature: define BRIGHTNESS_PWM_EN to add the brightness input and
// 16-step PWM dimming of the lit anode during the ON phase.
module display_scan_controller #(
  parameter int DIVISOR      = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int NUM_DIGITS   = 8
) (
  input  logic          clk,
  input  logic          rst,
  display_scan_if.slave bus,
  input  logic [7:0]    digit_en,
`ifdef BRIGHTNESS_PWM_EN
  input  logic [3:0]    brightness,
`endif
  output logic          frame_start,
  output logic [3:0]    bcd_out,
  output logic [7:0]    an
);

  localparam int              CNT_W      = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [2:0]      LAST_IDX   = 3'(NUM_DIGITS - 1);
  localparam logic [3:0]      NUM_D      = 4'(NUM_DIGITS);

  typedef enum logic {ST_BLANK = 1'b0, ST_ON = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  // Cleared by reset; the first running edge starts a fresh frame.
  logic             run;
  logic             boundary;

  logic             commit_pending;
  logic             commit_done_q;
  logic [3:0]       shadow [8];
  logic [3:0]       live   [8];

  logic [7:0]       an_nxt;
  logic [3:0]       bcd_nxt;
  logic             frame_start_nxt;
  logic             commit_done_nxt;
  logic             lit_ok;

  assign bus.wr_ready    = ~commit_pending;
  assign bus.commit_done = commit_done_q;

  // Next-state logic: cnt runs over the whole slot, the phase is derived
  // from where it sits relative to BLANK_CYCLES.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
    boundary  = 1'b0;
    if (!run) begin
      state_nxt = ST_BLANK;
      idx_nxt   = '0;
      cnt_nxt   = '0;
      boundary  = 1'b1;
    end else begin
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) state_nxt = ST_ON;
        end
        ST_ON: begin
          if (cnt == LAST_CNT) begin
            state_nxt = ST_BLANK;
            idx_nxt   = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
            boundary  = (idx == LAST_IDX);
          end
        end
        default: state_nxt = ST_BLANK;
      endcase
    end
  end

`ifdef BRIGHTNESS_PWM_EN
  logic [3:0] pwm_cnt, pwm_nxt;
  logic [3:0] bright, bright_nxt;

  // Brightness is captured on ON entry so a mid-slot change cannot glitch.
  always_comb begin
    pwm_nxt    = pwm_cnt;
    bright_nxt = bright;
    if (state_nxt == ST_ON) begin
      if (state != ST_ON) begin
        pwm_nxt    = '0;
        bright_nxt = brightness;
      end else begin
        pwm_nxt = pwm_cnt + 4'd1;
      end
    end
  end

  assign lit_ok = (pwm_nxt < bright_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      bright  <= '0;
    end else begin
      pwm_cnt <= pwm_nxt;
      bright  <= bright_nxt;
    end
  end
`else
  assign lit_ok = 1'b1;
`endif

  // Output logic: outputs are registered from the next state so they move on
  // the same edge as the state itself.
  always_comb begin
    an_nxt  = 8'hFF;
    bcd_nxt = 4'hF;
    if (state_nxt == ST_ON) begin
      bcd_nxt = live[idx_nxt];
      if (digit_en[idx_nxt] && lit_ok) an_nxt[idx_nxt] = 1'b0;
    end
    frame_start_nxt = boundary;
    commit_done_nxt = boundary && commit_pending;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_BLANK;
      idx           <= '0;
      cnt           <= '0;
      run           <= 1'b0;
      an            <= 8'hFF;
      bcd_out       <= 4'hF;
      frame_start   <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      cnt           <= cnt_nxt;
      run           <= 1'b1;
      an            <= an_nxt;
      bcd_out       <= bcd_nxt;
      frame_start   <= frame_start_nxt;
      commit_done_q <= commit_done_nxt;
    end
  end

  // Digit banks and commit tracking. A write can only land while nothing is
  // pending, so the shadow copied at the boundary is always stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_pending <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= 4'hF;
        live[i]   <= 4'hF;
      end
    end else begin
      if (boundary && commit_pending) begin
        live           <= shadow;
        commit_pending <= 1'b0;
      end else if (bus.wr_commit && !commit_pending) begin
        commit_pending <= 1'b1;
      end
      if (bus.wr_valid && !commit_pending && ({1'b0, bus.wr_addr} < NUM_D))
        shadow[bus.wr_addr] <= bus.wr_data;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller with DIVISOR=10, BLANK_CYCLES=2,
// NUM_DIGITS=4. A time-based reference model predicts every output each
// cycle; directed sequences add literal expectations, then random traffic.
module tb_display_scan_controller;
  localparam int DIV   = 10;
  localparam int BLNK  = 2;
  localparam int NUM   = 4;
  localparam int FRAME = DIV * NUM;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] digit_en = 8'hFF;
  logic       frame_start;
  logic [3:0] bcd_out;
  logic [7:0] an;

  display_scan_if bus();

  display_scan_controller #(.DIVISOR(DIV), .BLANK_CYCLES(BLNK), .NUM_DIGITS(NUM)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .digit_en   (digit_en),
    .frame_start(frame_start),
    .bcd_out    (bcd_out),
    .an         (an)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the frame is just elapsed cycles since the
  // scan started; slot and phase follow by division.
  int         t = 0;
  bit         started = 0;
  bit         m_valid = 0;
  bit         m_pend = 0;
  logic [3:0] m_shadow [8];
  logic [3:0] m_live   [8];
  logic [7:0] e_an;
  logic [3:0] e_bcd;
  logic       e_fs, e_cd, e_rdy;

  always @(posedge clk) begin
    int  slot, ph;
    bit  bnd, acc;
    if (rst) begin
      started = 0;
      m_pend  = 0;
      for (int i = 0; i < 8; i++) begin
        m_shadow[i] = 4'hF;
        m_live[i]   = 4'hF;
      end
      e_an  = 8'hFF;
      e_bcd = 4'hF;
      e_fs  = 0;
      e_cd  = 0;
      m_valid = 1;
    end else begin
      t = started ? t + 1 : 0;
      started = 1;
      bnd = (t % FRAME == 0);
      acc = bus.wr_valid && !m_pend;
      e_cd = bnd && m_pend;
      if (bnd && m_pend) begin
        for (int i = 0; i < 8; i++) m_live[i] = m_shadow[i];
        m_pend = 0;
      end else if (bus.wr_commit && !m_pend) begin
        m_pend = 1;
      end
      if (acc && bus.wr_addr < NUM) m_shadow[bus.wr_addr] = bus.wr_data;
      slot = (t / DIV) % NUM;
      ph   = t % DIV;
      e_fs = bnd;
      if (ph < BLNK) begin
        e_an  = 8'hFF;
        e_bcd = 4'hF;
      end else begin
        e_bcd = m_live[slot];
        e_an  = digit_en[slot] ? ~(8'h01 << slot) : 8'hFF;
      end
    end
    e_rdy = !m_pend;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("an", an, e_an);
      chk("bcd_out", bcd_out, e_bcd);
      chk("frame_start", frame_start, e_fs);
      chk("commit_done", bus.commit_done, e_cd);
      chk("wr_ready", bus.wr_ready, e_rdy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_write(input logic [2:0] addr, input logic [3:0] data);
    int n = 0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr;
    bus.wr_data  = data;
    while (!bus.wr_ready && n < 200) begin
      tick();
      n++;
    end
    chk("write_wait_bound", (n < 200), 1);
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    bus.wr_commit = 1'b1;
    tick();
    bus.wr_commit = 1'b0;
  endtask

  task automatic wait_commit();
    int n = 0;
    while (!bus.commit_done && n < 200) begin
      tick();
      n++;
    end
    chk("commit_wait_bound", (n < 200), 1);
    chk("commit_with_frame_start", frame_start, 1);
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!frame_start && n < 200) begin
      tick();
      n++;
    end
    chk("frame_wait_bound", (n < 200), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cd_seen;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_commit = 1'b0;
    ticks(3);
    chk("rst_an", an, 8'hFF);
    chk("rst_bcd", bcd_out, 4'hF);
    chk("rst_fs", frame_start, 0);
    chk("rst_ready", bus.wr_ready, 1);

    // Scan start
    rst = 1'b0;
    tick();
    chk("first_fs", frame_start, 1);
    chk("first_an", an, 8'hFF);
    ticks(2);
    chk("slot0_on_an", an, 8'hFE);
    chk("slot0_on_bcd", bcd_out, 4'hF);

    // Write + commit
    do_write(3'd0, 4'd3);
    do_write(3'd1, 4'd7);
    pulse_commit();
    chk("ready_low_pending", bus.wr_ready, 0);
    wait_commit();
    ticks(2);
    chk("commit_an0", an, 8'hFE);
    chk("commit_bcd0", bcd_out, 4'd3);
    ticks(10);
    chk("commit_an1", an, 8'hFD);
    chk("commit_bcd1", bcd_out, 4'd7);

    // Simultaneous write + commit
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = 3'd2;
    bus.wr_data   = 4'd5;
    bus.wr_commit = 1'b1;
    tick();
    bus.wr_valid  = 1'b0;
    bus.wr_commit = 1'b0;
    wait_commit();
    ticks(22);
    chk("simul_an2", an, 8'hFB);
    chk("simul_bcd2", bcd_out, 4'd5);

    // Backpressure
    pulse_commit();
    do_write(3'd0, 4'd9);
    tick();
    chk("bp_not_live_yet", bcd_out, 4'd3);
    pulse_commit();
    wait_commit();
    ticks(2);
    chk("bp_live_after_commit", bcd_out, 4'd9);

    // Masking and out-of-range address
    digit_en = 8'b0000_0010;
    do_write(3'd6, 4'd1);
    pulse_commit();
    wait_commit();
    ticks(2);
    chk("mask_slot0_an", an, 8'hFF);
    ticks(10);
    chk("mask_slot1_an", an, 8'hFD);
    chk("mask_slot1_bcd", bcd_out, 4'd7);
    ticks(40);
    digit_en = 8'hFF;

    // Reset while a commit is pending
    pulse_commit();
    tick();
    rst = 1'b1;
    ticks(2);
    chk("midrst_ready", bus.wr_ready, 1);
    chk("midrst_an", an, 8'hFF);
    chk("midrst_bcd", bcd_out, 4'hF);
    chk("midrst_cd", bus.commit_done, 0);
    rst = 1'b0;
    tick();
    chk("midrst_fs", frame_start, 1);
    cd_seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.commit_done) cd_seen++;
    end
    chk("midrst_no_commit", cd_seen, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 399) == 0);
      bus.wr_valid  = $urandom_range(0, 1);
      bus.wr_addr   = 3'($urandom_range(0, 7));
      bus.wr_data   = 4'($urandom_range(0, 15));
      bus.wr_commit = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) digit_en = 8'($urandom_range(0, 255));
      tick();
    end
    rst = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_commit = 1'b0;
    ticks(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
